// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcodes, FSM states and op classification.
// Defining SEQ_ALU_MULH_EN makes opcode 1001 (MULH) an iterative operation.
package seq_alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_PASA = 4'b0101;
  localparam logic [3:0] OP_PASB = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_MULH = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  typedef enum logic {ST_IDLE = 1'b0, ST_ITER = 1'b1} state_t;
  function automatic logic is_iterative(input logic [3:0] op);
`ifdef SEQ_ALU_MULH_EN
    return op == OP_MUL || op == OP_MULH || op == OP_DIVU || op == OP_REMU;
`else
    return op == OP_MUL || op == OP_DIVU || op == OP_REMU;
`endif
  endfunction
endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: start/busy/done handshake and operand/result bundle of seq_alu.
interface seq_alu_if #(parameter int WIDTH = 16);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             dz;
  modport master (output start, op, in1, in2, input busy, done, result, zero, carry, ovf, dz);
  modport slave (input start, op, in1, in2, output busy, done, result, zero, carry, ovf, dz);
endinterface

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: shared shift-add multiply / restoring divide datapath.
// o_hi/o_lo give the register values after the current step (product high/low, remainder/quotient).
module seq_alu_muldiv #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_div,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_last
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_div;
  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic [WIDTH:0]   w_sum, w_sh, w_trial;
  logic             w_ok;
  // multiply shifts {hi,lo} right after adding; divide shifts left then trial-subtracts
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_sh    = {r_hi, r_lo[WIDTH-1]};
    w_trial = w_sh - {1'b0, r_b};
    w_ok    = ~w_trial[WIDTH];
    o_hi    = r_div ? (w_ok ? w_trial[WIDTH-1:0] : w_sh[WIDTH-1:0]) : w_sum[WIDTH:1];
    o_lo    = r_div ? {r_lo[WIDTH-2:0], w_ok} : {w_sum[0], r_lo[WIDTH-1:1]};
  end
  assign o_last = i_step && r_cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_div <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(WIDTH - 1);
      r_div <= i_div;
      r_hi  <= '0;
      r_lo  <= i_div ? i_a : i_b;
      r_b   <= i_div ? i_b : i_a;
    end else if (i_step) begin
      r_cnt <= r_cnt - 1'b1;
      r_hi  <= o_hi;
      r_lo  <= o_lo;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle logic/arith ops and iterative MUL/MULH/DIVU/REMU.
// SEQ_ALU_MULH_EN enables MULH; otherwise opcode 1001 behaves as an illegal op.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave alu
);
  state_t           r_state;
  logic             r_done, r_zero, r_carry, r_ovf, r_dz, r_hi_sel;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_res, w_hi, w_lo, w_it_res;
  logic             w_carry, w_ovf, w_dz, w_iter, w_load, w_last;
  assign w_add    = {1'b0, alu.in1} + {1'b0, alu.in2};
  assign w_sub    = {1'b0, alu.in1} - {1'b0, alu.in2};
  assign w_dz     = (alu.op == OP_DIVU || alu.op == OP_REMU) && alu.in2 == '0;
  assign w_iter   = is_iterative(alu.op) && !w_dz;
  assign w_load   = r_state == ST_IDLE && alu.start && w_iter;
  assign w_it_res = r_hi_sel ? w_hi : w_lo;
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (alu.op)
      OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = alu.in1[WIDTH-1] == alu.in2[WIDTH-1] && w_res[WIDTH-1] != alu.in1[WIDTH-1];
      end
      OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = alu.in1[WIDTH-1] != alu.in2[WIDTH-1] && w_res[WIDTH-1] != alu.in1[WIDTH-1];
      end
      OP_AND:  w_res = alu.in1 & alu.in2;
      OP_OR:   w_res = alu.in1 | alu.in2;
      OP_NOT:  w_res = ~alu.in1;
      OP_PASA: w_res = alu.in1;
      OP_PASB: w_res = alu.in2;
      OP_XOR:  w_res = alu.in1 ^ alu.in2;
      OP_DIVU: w_res = '1;
      OP_REMU: w_res = alu.in1;
      default: w_res = '0;
    endcase
  end
  seq_alu_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_div  (alu.op[1]),
    .i_step (r_state == ST_ITER),
    .i_a    (alu.in1),
    .i_b    (alu.in2),
    .o_hi   (w_hi),
    .o_lo   (w_lo),
    .o_last (w_last)
  );
  // odd iterative opcodes (MULH, REMU) take the high register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
      r_hi_sel <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE && alu.start) begin
        r_hi_sel <= alu.op[0];
        if (w_iter) r_state <= ST_ITER;
        else begin
          r_done   <= 1'b1;
          r_result <= w_res;
          r_zero   <= w_res == '0;
          r_carry  <= w_carry;
          r_ovf    <= w_ovf;
          r_dz     <= w_dz;
        end
      end else if (w_last) begin
        r_state  <= ST_IDLE;
        r_done   <= 1'b1;
        r_result <= w_it_res;
        r_zero   <= w_it_res == '0;
        r_carry  <= 1'b0;
        r_ovf    <= 1'b0;
        r_dz     <= 1'b0;
      end
    end
  end
  assign alu.busy   = r_state == ST_ITER;
  assign alu.done   = r_done;
  assign alu.result = r_result;
  assign alu.zero   = r_zero;
  assign alu.carry  = r_carry;
  assign alu.ovf    = r_ovf;
  assign alu.dz     = r_dz;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu results, flags, latency and handshake.
module tb_seq_alu;
  import seq_alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  seq_alu_if #(.WIDTH(16)) alu ();
  seq_alu #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .alu(alu));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     output int lat, output int bcnt);
    @(negedge clk);
    alu.start = 1'b1;
    alu.op    = op;
    alu.in1   = a;
    alu.in2   = b;
    lat  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      alu.start = 1'b0;
      alu.in1   = 16'($urandom);
      alu.in2   = 16'($urandom);
      lat++;
      if (alu.busy) bcnt++;
    end while (!alu.done && lat < 40);
  endtask
  task automatic op_chk(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] res, input logic [3:0] flags,
                        input int exp_lat);
    int lat, bcnt;
    run(op, a, b, lat, bcnt);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".busy_cycles"}, bcnt, exp_lat - 1);
    chk({tag, ".busy_at_done"}, alu.busy, 1'b0);
    chk({tag, ".res"}, alu.result, res);
    chk({tag, ".flags"}, {alu.zero, alu.carry, alu.ovf, alu.dz}, flags);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, ndone, lat, bcnt;
    alu.start = 1'b0;
    alu.op    = '0;
    alu.in1   = '0;
    alu.in2   = '0;
    repeat (2) @(negedge clk);
    chk("reset.ctl", {alu.busy, alu.done, alu.zero, alu.carry, alu.ovf, alu.dz}, 6'b0);
    chk("reset.res", alu.result, 16'h0);
    rst_n = 1'b1;
    // flags are {zero, carry, ovf, dz}
    op_chk("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0010, 1);
    op_chk("sub_zero", OP_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b1000, 1);
    op_chk("sub_borrow", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100, 1);
    op_chk("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0010, 1);
    op_chk("add_carry", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 1);
    op_chk("and", OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1);
    op_chk("or", OP_OR, 16'hF0F0, 16'h0FF0, 16'hFFF0, 4'b0000, 1);
    op_chk("not", OP_NOT, 16'hF0F0, 16'h0FF0, 16'h0F0F, 4'b0000, 1);
    op_chk("pass1", OP_PASA, 16'h1357, 16'h2468, 16'h1357, 4'b0000, 1);
    op_chk("pass2", OP_PASB, 16'h1357, 16'h2468, 16'h2468, 4'b0000, 1);
    op_chk("illegal", 4'b1100, 16'h1234, 16'h5678, 16'h0000, 4'b1000, 1);
    op_chk("mul", OP_MUL, 16'h0123, 16'h0100, 16'h2300, 4'b0000, 17);
    op_chk("mul_big", OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000, 17);
`ifdef SEQ_ALU_MULH_EN
    op_chk("mulh", OP_MULH, 16'h8000, 16'h0004, 16'h0002, 4'b0000, 17);
`else
    op_chk("mulh_off", OP_MULH, 16'h8000, 16'h0004, 16'h0000, 4'b1000, 1);
`endif
    op_chk("divu", OP_DIVU, 16'd100, 16'd7, 16'd14, 4'b0000, 17);
    op_chk("remu", OP_REMU, 16'd100, 16'd7, 16'd2, 4'b0000, 17);
    op_chk("divu_big", OP_DIVU, 16'hFFFF, 16'h0003, 16'h5555, 4'b0000, 17);
    op_chk("remu_zero", OP_REMU, 16'd49, 16'd7, 16'd0, 4'b1000, 17);
    op_chk("divu_dz", OP_DIVU, 16'h1234, 16'h0000, 16'hFFFF, 4'b0001, 1);
    op_chk("remu_dz", OP_REMU, 16'h1234, 16'h0000, 16'h1234, 4'b0001, 1);
    // start during busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    alu.start = 1'b1;
    alu.op    = OP_DIVU;
    alu.in1   = 16'd100;
    alu.in2   = 16'd7;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      alu.start = n == 5;
      if (n == 5) begin
        alu.op  = OP_ADD;
        alu.in1 = 16'h0001;
        alu.in2 = 16'h0001;
      end
    end while (!alu.done && n < 40);
    chk("ignore.lat", n, 17);
    chk("ignore.res", alu.result, 16'd14);
    alu.start = 1'b1;
    alu.op    = OP_ADD;
    alu.in1   = 16'd2;
    alu.in2   = 16'd3;
    @(negedge clk);
    alu.start = 1'b0;
    chk("back2back.done", alu.done, 1'b1);
    chk("back2back.res", alu.result, 16'd5);
    // asynchronous reset in the middle of a MUL
    @(negedge clk);
    alu.start = 1'b1;
    alu.op    = OP_MUL;
    alu.in1   = 16'h0123;
    alu.in2   = 16'h0100;
    repeat (8) begin
      @(negedge clk);
      alu.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort.ctl", {alu.busy, alu.done, alu.zero, alu.carry, alu.ovf, alu.dz}, 6'b0);
    chk("abort.res", alu.result, 16'h0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (alu.done || alu.busy) ndone++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (alu.done || alu.busy) ndone++;
    end
    chk("abort.no_done", ndone, 0);
    run(OP_XOR, 16'hF0F0, 16'h0FF0, lat, bcnt);
    chk("xor.lat", lat, 1);
    chk("xor.res", alu.result, 16'hFF00);
    chk("xor.flags", {alu.zero, alu.carry, alu.ovf, alu.dz}, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
